// File: rtl/alu32_mul_seq.sv
`default_nettype none
// =============================================================================
// Module      : alu32_mul_seq
// Description : Unsigned 32x32->64 shift-add multiplier sequencer that borrows
//               an external alu32 as its adder for 32 fixed iterations.
// Revision    : 1.0 - initial release
// =============================================================================
module alu32_mul_seq #(
   parameter logic [3:0] OP_ADD  = 4'b0010,
   parameter logic [3:0] OP_IDLE = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [4:0] c_LAST_ITER = 5'd31;

   state_t      r_state;
   logic [31:0] r_acc_hi;
   logic [31:0] r_acc_lo;
   logic [31:0] r_m;
   logic [4:0]  r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc_hi <= 32'd0;
         r_acc_lo <= 32'd0;
         r_m      <= 32'd0;
         r_cnt    <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m      <= multiplicand;
                  r_acc_lo <= multiplier;
                  r_acc_hi <= 32'd0;
                  r_cnt    <= 5'd0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               // The ALU carry becomes the new top bit; the sum then shifts right by one.
               {r_acc_hi, r_acc_lo} <= {alu_cout, alu_result, r_acc_lo[31:1]};
               r_cnt                <= r_cnt + 5'd1;
               if (r_cnt == c_LAST_ITER) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      alu_a  = 32'd0;
      alu_b  = 32'd0;
      alu_op = OP_IDLE;
      if (r_state == S_RUN) begin
         alu_a  = r_acc_hi;
         alu_b  = r_acc_lo[0] ? r_m : 32'd0;
         alu_op = OP_ADD;
      end
   end

   assign busy    = (r_state == S_RUN);
   assign done    = (r_state == S_DONE);
   assign product = {r_acc_hi, r_acc_lo};

endmodule
`default_nettype wire

// File: tb/tb_alu32_mul_seq.sv
`default_nettype none
// =============================================================================
// Module      : tb_alu32_mul_seq
// Description : Directed, table-driven bench for alu32_mul_seq with an ALU model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_alu32_mul_seq;

   localparam logic [3:0] c_OP_ADD  = 4'b0010;
   localparam logic [3:0] c_OP_IDLE = 4'b0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_cout;
   logic [32:0] alu_sum;

   int checks   = 0;
   int failures = 0;

   alu32_mul_seq #(
      .OP_ADD  (c_OP_ADD),
      .OP_IDLE (c_OP_IDLE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_cout     (alu_cout)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the external alu32: add or AND.
   always_comb begin
      if (alu_op == c_OP_ADD) alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      else                    alu_sum = {1'b0, alu_a & alu_b};
   end
   assign alu_result = alu_sum[31:0];
   assign alu_cout   = alu_sum[32];

   typedef struct {
      logic [31:0] m;
      logic [31:0] q;
      logic [63:0] p;
      bit          zero_b;
      bit          cout;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [31:0] m, input logic [31:0] q);
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges after the accepting edge until done (bounded at 40).
   task automatic wait_done(input bit spam, output int cyc, output int busy_cnt,
                            output bit cout_seen, output int nz_b);
      cyc = 0; busy_cnt = 0; cout_seen = 1'b0; nz_b = 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) break;
         if (busy) busy_cnt++;
         if (busy && alu_b != 32'd0) nz_b++;
         if (busy && alu_cout) cout_seen = 1'b1;
         if (spam) begin
            if (cyc >= 5 && cyc <= 10) begin
               start        = 1'b1;
               multiplicand = $urandom;
               multiplier   = $urandom;
            end else begin
               start = 1'b0;
            end
         end
      end
      if (spam && done) start = 1'b1;
   endtask

   task automatic post_done(input string name, input logic [63:0] exp);
      @(negedge clk);
      chk({name, " done_single"}, {63'd0, done}, 64'd0);
      chk({name, " idle_busy"}, {63'd0, busy}, 64'd0);
      chk({name, " held_product"}, product, exp);
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string name, input bit spam);
      int cyc, bc, nzb;
      bit cs;
      launch(v.m, v.q);
      wait_done(spam, cyc, bc, cs, nzb);
      chk({name, " latency"}, 64'(cyc), 64'd33);
      chk({name, " busy_cycles"}, 64'(bc), 64'd32);
      chk({name, " product"}, product, v.p);
      chk({name, " cout_seen"}, {63'd0, cs}, {63'd0, v.cout});
      if (v.zero_b) chk({name, " alu_b_nonzero"}, 64'(nzb), 64'd0);
      post_done(name, v.p);
   endtask

   initial begin
      int cyc, bc, nzb;
      bit cs;
      vec_t tmp;

      vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1};
      vecs[2] = '{32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
      vecs[3] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vecs[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
      vecs[5] = '{32'hDEAD_BEEF, 32'h0000_0001, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0};
      vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; multiplicand = 32'd0; multiplier = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset product", product, 64'd0);
      chk("reset alu_a", {32'd0, alu_a}, 64'd0);
      chk("reset alu_b", {32'd0, alu_b}, 64'd0);
      chk("reset alu_op", {60'd0, alu_op}, {60'd0, c_OP_IDLE});
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
      end

      // start asserted with junk operands mid-run and during DONE is ignored
      tmp = '{32'h0000_1234, 32'h0000_0100, 64'h0000_0000_0012_3400, 1'b0, 1'b0};
      run_vec(tmp, "ignore_start", 1'b1);

      // Back-to-back: start held high, second request taken at E34
      @(negedge clk);
      multiplicand = 32'd1000; multiplier = 32'd3000; start = 1'b1;
      @(posedge clk);
      #1 multiplicand = 32'hFFFF_0000; multiplier = 32'h0001_0000;
      wait_done(1'b0, cyc, bc, cs, nzb);
      chk("b2b first latency", 64'(cyc), 64'd33);
      chk("b2b first product", product, 64'd3000000);
      @(negedge clk);
      chk("b2b gap done", {63'd0, done}, 64'd0);
      chk("b2b gap busy", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(1'b0, cyc, bc, cs, nzb);
      chk("b2b second latency", 64'(cyc), 64'd33);
      chk("b2b second busy", 64'(bc), 64'd32);
      chk("b2b second product", product, 64'h0000_FFFF_0000_0000);
      post_done("b2b second", 64'h0000_FFFF_0000_0000);

      // Asynchronous reset at RUN cycle 17
      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (17) @(negedge clk);
      chk("midrun busy before reset", {63'd0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun reset busy", {63'd0, busy}, 64'd0);
      chk("midrun reset done", {63'd0, done}, 64'd0);
      chk("midrun reset product", product, 64'd0);
      chk("midrun reset alu_a", {32'd0, alu_a}, 64'd0);
      chk("midrun reset alu_b", {32'd0, alu_b}, 64'd0);
      chk("midrun reset alu_op", {60'd0, alu_op}, {60'd0, c_OP_IDLE});
      @(negedge clk);
      rst_n = 1'b1;
      wait_done(1'b0, cyc, bc, cs, nzb);
      chk("after reset no done", {63'd0, done}, 64'd0);
      chk("after reset no busy", 64'(bc), 64'd0);
      tmp = '{32'd7, 32'd6, 64'd42, 1'b0, 1'b0};
      run_vec(tmp, "after_reset", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu32_mul_seq.md
# alu32_mul_seq

Multi-cycle sequencer that computes an unsigned 32x32→64-bit product by time-sharing one external `alu32` instance as its adder. Each cycle it drives the ALU operand and opcode ports and captures `Result` and `Cout`. It sits beside the ALU in the execute stage and owns the ALU for the whole of an accepted multiply. It uses fixed 32-iteration shift-add with no early termination, so latency does not depend on the data.

## Interface
Parameters:
- `OP_ADD`, default 4'b0010: ALU opcode for add, driven during iterations.
- `OP_IDLE`, default 4'b0000: ALU opcode (AND) driven when not iterating.

Ports:
- `clk`  in  1: single clock, all state on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a multiply; sampled only in IDLE.
- `multiplicand`  in  32: operand M; captured when `start` is accepted.
- `multiplier`  in  32: operand Q; captured when `start` is accepted.
- `busy`  out  1: high while in RUN.
- `done`  out  1: single-cycle pulse; `product` is valid in that cycle.
- `product`  out  64: result; held stable from DONE until the next accepted `start`.
- `alu_a`  out  32: to ALU `A`.
- `alu_b`  out  32: to ALU `B`.
- `alu_op`  out  4: to ALU `Op`.
- `alu_result`  in  32: from ALU `Result`; combinational path.
- `alu_cout`  in  1: from ALU `Cout`; ALU `Zero` is unused.

## Operation
- Internal registers:
  - `acc_hi[31:0]`
  - `acc_lo[31:0]`
  - `m[31:0]`
  - `cnt[4:0]`
  - `state` ∈ {IDLE, RUN, DONE}
- `product = {acc_hi, acc_lo}` at all times.
- IDLE:
  - With `start`=1, load `m←multiplicand`, `acc_lo←multiplier`, `acc_hi←0`, `cnt←0`, then go to RUN.
  - With `start`=0, hold all state.
- RUN:
  - ALU drive: `alu_a=acc_hi`, `alu_b = acc_lo[0] ? m : 0`, `alu_op=OP_ADD`.
  - Each edge: `{acc_hi, acc_lo} ← {alu_cout, alu_result, acc_lo[31:1]}`, then `cnt←cnt+1`.
  - With `acc_lo[0]`=0 the ALU adds zero, so `alu_cout` is 0 and the step is a plain shift.
  - On the edge where `cnt`=31, perform the final iteration and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE (no queuing). A request is accepted only in a cycle with `start`=1 and state IDLE.
- Outside RUN: `alu_a`=0, `alu_b`=0, `alu_op`=`OP_IDLE`. These are combinational from state and registers.
- Width rules:
  - All arithmetic is unsigned.
  - The 33-bit sum `{alu_cout, alu_result}` never overflows, because `acc_hi < 2^32` and `m < 2^32`.
  - The final product is exact modulo 2^64, and equals the true product.
- Reset (`rst_n`=0), at any time including mid-RUN: immediately force IDLE, clear `acc_hi`, `acc_lo`, `m` and `cnt`, with no `done` pulse. The aborted operation is lost.
- Reset values: `busy`=0, `done`=0, `product`=0, `alu_a`=0, `alu_b`=0, `alu_op`=`OP_IDLE`.

## Timing
- Edge E0 samples `start`=1 in IDLE. From E0 to E32, `busy`=1 (32 cycles).
- Edges E1..E32 each perform one iteration. E32 is the last one, taken with `cnt`=31.
- Between E32 and E33: `done`=1, `busy`=0, final `product` valid.
- E33 returns to IDLE and `done` drops. A `start` may be sampled at E34 at the earliest, giving a minimum issue interval of 34 cycles.
- Latency from accepted `start` to `done` is 33 cycles, fixed regardless of operand values.
- The ALU path is combinational within one cycle: `alu_a`/`alu_b` → `alu_result`/`alu_cout` → `acc` registers. Meeting timing requires the full 32-bit ripple delay plus the mux to fit in one period.
- During RUN, `product` shows intermediate values. Consumers sample it only while `done`=1, or afterwards while in IDLE.

## Test plan
- Small operands: `start` with M=0x0000_0003, Q=0x0000_0005 → `done` 33 cycles after accept; `product`=0x0000_0000_0000_000F; `busy` high for exactly 32 cycles.
- Maximum values: M=Q=0xFFFF_FFFF → `product`=0xFFFF_FFFE_0000_0001. Also check that `alu_cout`=1 is captured on iterations where Q's bit is 1 and the running sum exceeds 2^32−1.
- Zero and shift edge cases:
  - M=0x1234_5678, Q=0 → `product`=0; `alu_b`=0 on every RUN cycle.
  - M=0x8000_0000, Q=0x0000_0002 → `product`=0x0000_0001_0000_0000.
- `start` outside IDLE: assert `start` with new operands on RUN cycles 5..10 and during DONE → ignored; the original product is delivered, and `done` pulses once only.
- Reset mid-run: drop `rst_n` at RUN cycle 17 → outputs and `product` are 0 asynchronously. With no new `start`, no `done` follows. A new `start` after release (M=7, Q=6) gives `product`=42.
- Back-to-back: a second `start` held high continuously is accepted at the first IDLE edge after DONE (E34). Both products are correct, and each `done` is a single cycle.
